// File: rtl/mct_mem_pkg.sv
// Shared types and constants for the mct AXI memory responder: AR queue entry, FSM state
// encodings, line size and a saturating counter helper.
package mct_mem_pkg;

    localparam int LINE_BYTES = 64;
    localparam int LINE_OFS_W = 6;
    localparam int MAX_LINE_W = 32;

    typedef struct packed {
        logic [MAX_LINE_W-1:0] line;
        logic [7:0]            len;
    } ar_entry_t;

    typedef logic [0:0] rd_state_t;
    localparam rd_state_t R_IDLE  = 1'b0;
    localparam rd_state_t R_BURST = 1'b1;

    typedef logic [1:0] wr_state_t;
    localparam wr_state_t W_IDLE = 2'd0;
    localparam wr_state_t W_DATA = 2'd1;
    localparam wr_state_t W_RESP = 2'd2;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [1:0] step);
        logic [32:0] sum;
        sum = {1'b0, value} + 33'(step);
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/mct_mem_ar_fifo.sv
// Small FIFO of pending read-burst requests; the head entry stays visible while its burst
// is being served and is popped when the burst's last beat is issued.
import mct_mem_pkg::*;

module mct_mem_ar_fifo #(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  ar_entry_t push_data,
    input  logic      pop,
    output ar_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    ar_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = entries[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) entries[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mct_axi_mem_responder.sv
// AXI4 slave scratch memory serving INCR read/write bursts from a line-wide RAM.
// Define MCT_MEM_STATS_EN to add saturating beat/burst statistics outputs.
import mct_mem_pkg::*;

module mct_axi_mem_responder #(
    parameter int C_S_AXI_ADDR_WIDTH = 64,
    parameter int C_S_AXI_DATA_WIDTH = 512,
    parameter int C_MEM_DEPTH_LOG2   = 10,
    parameter int C_RD_QUEUE_DEPTH   = 4
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst_n,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                      s_axi_awlen,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wlast,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                      s_axi_arlen,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                            s_axi_rlast,
    output logic                            err_wlast
`ifdef MCT_MEM_STATS_EN
    ,
    output logic [31:0]                     stat_rd_beats,
    output logic [31:0]                     stat_wr_beats,
    output logic [31:0]                     stat_bursts
`endif
);

    localparam int DATA_W    = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W    = DATA_W / 8;
    localparam int DEPTH_W   = C_MEM_DEPTH_LOG2;
    localparam int MEM_LINES = 1 << DEPTH_W;

    logic [DATA_W-1:0] mem [MEM_LINES];

    // Readys stay low during reset and for the first cycle after release.
    logic rdy_en;
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) rdy_en <= 1'b0;
        else           rdy_en <= 1'b1;
    end

    logic      ar_hs, ar_full, ar_empty, rd_pop;
    ar_entry_t ar_push, ar_head;

    assign s_axi_arready = rdy_en && !ar_full;
    assign ar_hs         = s_axi_arvalid && s_axi_arready;
    assign ar_push       = '{line: MAX_LINE_W'(s_axi_araddr[LINE_OFS_W +: DEPTH_W]), len: s_axi_arlen};

    mct_mem_ar_fifo #(
        .DEPTH(C_RD_QUEUE_DEPTH)
    ) u_ar_fifo (
        .clk      (ap_clk),
        .rst_n    (ap_rst_n),
        .push     (ar_hs),
        .push_data(ar_push),
        .pop      (rd_pop),
        .head     (ar_head),
        .full     (ar_full),
        .empty    (ar_empty)
    );

    rd_state_t          rd_state;
    logic [8:0]         rd_cnt;
    logic               rd_issue, rd_last_issue, r_hs;
    logic [DEPTH_W-1:0] rd_line;
    logic [2:0]         rd_pending;
    logic               vld_p0, last_p0;
    logic [DATA_W-1:0]  data_p0;
    logic [DATA_W-1:0]  skid_data [2];
    logic [1:0]         skid_last;
    logic               skid_wr_ptr, skid_rd_ptr;
    logic [1:0]         skid_cnt;

    assign r_hs          = s_axi_rvalid && s_axi_rready;
    // Beats in the skid plus the one in the RAM stage, net of a beat leaving this cycle.
    assign rd_pending    = 3'(skid_cnt) + 3'(vld_p0) - 3'(r_hs);
    assign rd_issue      = (rd_state == R_BURST) && (rd_pending < 3'd2);
    assign rd_last_issue = rd_issue && (rd_cnt == {1'b0, ar_head.len});
    assign rd_pop        = rd_last_issue;
    assign rd_line       = ar_head.line[DEPTH_W-1:0] + DEPTH_W'(rd_cnt);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rd_state <= R_IDLE;
            rd_cnt   <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (!ar_empty) begin
                        rd_state <= R_BURST;
                        rd_cnt   <= '0;
                    end
                end
                default: begin
                    if (rd_issue) begin
                        rd_cnt <= rd_cnt + 9'd1;
                        if (rd_last_issue) rd_state <= R_IDLE;
                    end
                end
            endcase
        end
    end

    // Stage p0: synchronous RAM read.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) vld_p0 <= 1'b0;
        else           vld_p0 <= rd_issue;
    end

    always_ff @(posedge ap_clk) begin
        if (rd_issue) begin
            data_p0 <= mem[rd_line];
            last_p0 <= rd_last_issue;
        end
    end

    // Stage p1: two-entry output skid.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            skid_cnt    <= '0;
            skid_wr_ptr <= 1'b0;
            skid_rd_ptr <= 1'b0;
        end else begin
            if (vld_p0) skid_wr_ptr <= !skid_wr_ptr;
            if (r_hs)   skid_rd_ptr <= !skid_rd_ptr;
            skid_cnt <= skid_cnt + 2'(vld_p0) - 2'(r_hs);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (vld_p0) begin
            skid_data[skid_wr_ptr] <= data_p0;
            skid_last[skid_wr_ptr] <= last_p0;
        end
    end

    assign s_axi_rvalid = (skid_cnt != 2'd0);
    assign s_axi_rdata  = skid_data[skid_rd_ptr];
    assign s_axi_rlast  = s_axi_rvalid && skid_last[skid_rd_ptr];

    wr_state_t          wr_state;
    logic [DEPTH_W-1:0] wr_base, wr_line;
    logic [7:0]         wr_len;
    logic [8:0]         wr_cnt;
    logic               aw_hs, w_hs, wr_final, err_q;

    assign s_axi_awready = rdy_en && (wr_state == W_IDLE);
    assign s_axi_wready  = (wr_state == W_DATA);
    assign s_axi_bvalid  = (wr_state == W_RESP);
    assign aw_hs         = s_axi_awvalid && s_axi_awready;
    assign w_hs          = s_axi_wvalid && s_axi_wready;
    assign wr_final      = (wr_cnt == {1'b0, wr_len});
    assign wr_line       = wr_base + DEPTH_W'(wr_cnt);
    assign err_wlast     = err_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_state <= W_IDLE;
            wr_cnt   <= '0;
            err_q    <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        wr_state <= W_DATA;
                        wr_cnt   <= '0;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        wr_cnt <= wr_cnt + 9'd1;
                        if (s_axi_wlast != wr_final) err_q <= 1'b1;
                        if (wr_final) wr_state <= W_RESP;
                    end
                end
                default: begin
                    if (s_axi_bready) wr_state <= W_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (aw_hs) begin
            wr_base <= s_axi_awaddr[LINE_OFS_W +: DEPTH_W];
            wr_len  <= s_axi_awlen;
        end
    end

    // A same-cycle read of this line still sees the old contents (read-first).
    always_ff @(posedge ap_clk) begin
        if (w_hs) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) mem[wr_line][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

`ifdef MCT_MEM_STATS_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stat_rd_beats <= '0;
            stat_wr_beats <= '0;
            stat_bursts   <= '0;
        end else begin
            stat_rd_beats <= sat_inc(stat_rd_beats, 2'(r_hs));
            stat_wr_beats <= sat_inc(stat_wr_beats, 2'(w_hs));
            stat_bursts   <= sat_inc(stat_bursts, 2'(ar_hs) + 2'(aw_hs));
        end
    end
`endif

    logic unused_bits;
    assign unused_bits = ^{s_axi_awaddr, s_axi_araddr, ar_head.line};

endmodule

// File: tb/tb_mct_axi_mem_responder.sv
// Scoreboard bench for mct_axi_mem_responder: writes go to a byte-accurate model, reads
// push expected beats at AR time and a negedge monitor pops and compares R beats.
`timescale 1ns/1ps

module tb_mct_axi_mem_responder;

    localparam int AW    = 64;
    localparam int DW    = 512;
    localparam int SW    = DW / 8;
    localparam int DL    = 10;
    localparam int LINES = 1 << DL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          awvalid = 1'b0, awready;
    logic [AW-1:0] awaddr = '0;
    logic [7:0]    awlen = '0;
    logic          wvalid = 1'b0, wready;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic          wlast = 1'b0;
    logic          bvalid, bready = 1'b0;
    logic          arvalid = 1'b0, arready;
    logic [AW-1:0] araddr = '0;
    logic [7:0]    arlen = '0;
    logic          rvalid, rready = 1'b0;
    logic [DW-1:0] rdata;
    logic          rlast;
    logic          err_wlast;
`ifdef MCT_MEM_STATS_EN
    logic [31:0]   stat_rd_beats, stat_wr_beats, stat_bursts;
`endif

    always #5 clk = ~clk;

    mct_axi_mem_responder dut (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_wlast(wlast), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rlast(rlast),
        .err_wlast(err_wlast)
`ifdef MCT_MEM_STATS_EN
        , .stat_rd_beats(stat_rd_beats), .stat_wr_beats(stat_wr_beats), .stat_bursts(stat_bursts)
`endif
    );

    logic [DW-1:0] model [LINES];
    logic [DW-1:0] sb_data [$];
    logic          sb_last [$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            r_hs_cnt = 0;
    int            rmode = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int kind, input int seed, input int i);
        case (kind)
            0:       return DW'(i);
            1:       return '1;
            2:       return '0;
            default: return {16{32'(seed) * 32'h9E37_79B9 + 32'(i) * 32'h0101_0101}};
        endcase
    endfunction

    // rready pattern: 0 = held low, 1 = held high, 2 = toggles every cycle.
    initial begin
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0:       rready = 1'b0;
                1:       rready = 1'b1;
                default: rready = !rready;
            endcase
        end
    end

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("r_hold_valid", DW'(rvalid), DW'(1));
                chk("r_hold_data", rdata, prev_data);
            end
            if (rvalid && rready) begin
                chk("r_expected", DW'(sb_data.size() != 0), DW'(1));
                if (sb_data.size() != 0) begin
                    chk("r_data", rdata, sb_data.pop_front());
                    chk("r_last", DW'(rlast), DW'(sb_last.pop_front()));
                end
                r_hs_cnt++;
            end
            prev_stall = rvalid && !rready;
            prev_data  = rdata;
        end
    end

    task automatic do_aw(input logic [AW-1:0] a, input logic [7:0] l);
        int t = 0;
        awaddr = a; awlen = l; awvalid = 1'b1;
        @(negedge clk);
        while (!awready && t < 200) begin @(negedge clk); t++; end
        chk("aw_ready", DW'(awready), DW'(1));
        @(posedge clk); #1 awvalid = 1'b0;
    endtask

    task automatic wr_burst(input logic [AW-1:0] a, input logic [7:0] l, input int kind,
                            input int seed, input logic [SW-1:0] strb, input int wlast_beat);
        logic [DL-1:0] idx;
        int t;
        do_aw(a, l);
        for (int i = 0; i <= int'(l); i++) begin
            wdata = beat_data(kind, seed, i); wstrb = strb; wlast = (i == wlast_beat); wvalid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!wready && t < 200) begin @(negedge clk); t++; end
            chk("w_ready", DW'(wready), DW'(1));
            idx = a[6 +: DL] + DL'(i);
            for (int b = 0; b < SW; b++) if (strb[b]) model[idx][b*8 +: 8] = wdata[b*8 +: 8];
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b1; t = 0;
        @(negedge clk);
        while (!bvalid && t < 200) begin @(negedge clk); t++; end
        chk("b_valid", DW'(bvalid), DW'(1));
        @(posedge clk); #1 bready = 1'b0;
        @(negedge clk);
        chk("b_clear", DW'(bvalid), DW'(0));
        @(posedge clk); #1;
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [7:0] l);
        logic [DL-1:0] idx;
        for (int i = 0; i <= int'(l); i++) begin
            idx = a[6 +: DL] + DL'(i);
            sb_data.push_back(model[idx]);
            sb_last.push_back(i == int'(l));
        end
    endtask

    task automatic do_ar(input logic [AW-1:0] a, input logic [7:0] l);
        int t = 0;
        push_exp(a, l);
        araddr = a; arlen = l; arvalid = 1'b1;
        @(negedge clk);
        while (!arready && t < 500) begin @(negedge clk); t++; end
        chk("ar_ready", DW'(arready), DW'(1));
        @(posedge clk); #1 arvalid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb_data.size() != 0 || rvalid) && t < 3000) begin @(negedge clk); t++; end
        chk("drain_left", DW'(sb_data.size()), DW'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        int base, t;
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t;
        rmode = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", DW'(arready), DW'(0));
        chk("rst_awready", DW'(awready), DW'(0));
        chk("rst_wready", DW'(wready), DW'(0));
        chk("rst_bvalid", DW'(bvalid), DW'(0));
        chk("rst_rvalid", DW'(rvalid), DW'(0));
        chk("rst_rlast", DW'(rlast), DW'(0));
        chk("rst_err", DW'(err_wlast), DW'(0));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Known contents for lines 0..63.
        wr_burst(64'h0, 8'd63, 3, 1, '1, 63);

        // Four-beat write of beat indices, read back.
        wr_burst(64'h0, 8'd3, 0, 0, '1, 3);
        do_ar(64'h0, 8'd3);
        drain();
        chk("err_after_good", DW'(err_wlast), DW'(0));

        // Byte-masked write over a zeroed line.
        wr_burst(64'h40, 8'd0, 2, 0, '1, 0);
        wr_burst(64'h40, 8'd0, 1, 0, SW'(1), 0);
        do_ar(64'h40, 8'd0);
        drain();

        // AR queue fills while R is stalled; fifth request waits for the first burst.
        rmode = 0;
        do_ar(64'h000, 8'd3);
        do_ar(64'h100, 8'd3);
        do_ar(64'h200, 8'd3);
        do_ar(64'h300, 8'd3);
        push_exp(64'h380, 8'd3);
        araddr = 64'h380; arlen = 8'd3; arvalid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("ar_full_block", DW'(arready), DW'(0));
        end
        rmode = 1;
        t = 0;
        @(negedge clk);
        while (!arready && t < 500) begin @(negedge clk); t++; end
        chk("ar_after_drain", DW'(arready), DW'(1));
        @(posedge clk); #1 arvalid = 1'b0;
        drain();

        // rready toggling across a 16-beat burst.
        rmode = 2;
        base = r_hs_cnt;
        do_ar(64'h0, 8'd15);
        drain();
        chk("toggle_beats", DW'(r_hs_cnt - base), DW'(16));
        rmode = 1;

        // Burst crossing the top of memory wraps to line 0.
        wr_burst(64'hFFC0, 8'd1, 3, 7, '1, 1);
        do_ar(64'hFFC0, 8'd1);
        drain();

        // wlast on the wrong beat sets the sticky error; data still lands per awlen.
        chk("err_before", DW'(err_wlast), DW'(0));
        wr_burst(64'h800, 8'd1, 3, 9, '1, 0);
        chk("err_set", DW'(err_wlast), DW'(1));
        do_ar(64'h800, 8'd1);
        drain();
        chk("err_sticky", DW'(err_wlast), DW'(1));

        // Asynchronous reset in the middle of an 8-beat read.
        base = r_hs_cnt;
        do_ar(64'h0, 8'd7);
        t = 0;
        while (r_hs_cnt < base + 2 && t < 200) begin @(posedge clk); t++; end
        chk("mid_beats", DW'(r_hs_cnt >= base + 2), DW'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", DW'(rvalid), DW'(0));
        chk("mid_rst_rlast", DW'(rlast), DW'(0));
        chk("mid_rst_arready", DW'(arready), DW'(0));
        chk("mid_rst_err", DW'(err_wlast), DW'(0));
        sb_data.delete();
        sb_last.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_awready", DW'(awready), DW'(1));
        chk("post_rst_rvalid", DW'(rvalid), DW'(0));
        do_ar(64'h80, 8'd3);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
